vctrl_obuf_drain: RTL

- Read-side sequencer for the banked, shuffled OBuf.
- After a V-array pass completes, it walks every (row, col) position and regenerates the write-side bank-group select and shuffled per-bank addresses.
- Issues 1-cycle-latency SRAM reads and streams each row's OBufBank/2 lanes out over a valid/ready interface, tagged with row and column.
- Sits between the OBuf SRAM macros and the writeback/DMA path.

---
 rtl/vctrl_obuf_drain_pkg.sv | 49 ++++
 rtl/vctrl_obuf_skid.sv | 57 +++++
 rtl/vctrl_obuf_drain.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/vctrl_obuf_drain_pkg.sv
// ============================================================================
// Module  : vctrl_obuf_drain_pkg
// Brief   : Shared sizing, types and address-shuffle helper for the OBuf drain.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package vctrl_obuf_drain_pkg;

  localparam int OBufBank  = 8;
  localparam int OBufDepth = 256;
  localparam int VRowLoop  = 16;
  localparam int VColLoop  = 16;
  localparam int DataWidth = 32;

  localparam int BankHalf = OBufBank / 2;
  localparam int AddrW    = $clog2(OBufDepth);
  localparam int RowW     = $clog2(VRowLoop);
  localparam int ColW     = (VColLoop > 1) ? $clog2(VColLoop) : 1;
  localparam int ShufW    = $clog2(OBufBank) - 1;
  localparam int CfgRowW  = $clog2(VRowLoop) + 1;
  localparam int CfgColW  = $clog2(VColLoop) + 1;

  typedef logic [AddrW-1:0] obuf_addr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } drain_state_e;

  // Must stay bit-identical to the write-side converter: the lane offset wraps
  // inside the shuffle field and never carries into the stable (column) field.
  function automatic obuf_addr_t shuffle_addr(input logic [ColW-1:0] stable,
                                              input logic [RowW-1:0] row,
                                              input int              lane);
    obuf_addr_t        a;
    logic [ShufW-1:0]  sh;
    sh = ShufW'(row >> 1);
    a = '0;
    a[ShufW-1:0]     = sh + ShufW'(lane);
    a[ShufW +: ColW] = stable;
    return a;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vctrl_obuf_skid.sv
// ============================================================================
// Module  : vctrl_obuf_skid
// Brief   : Two-entry valid/ready FIFO holding one drained row plus its tags.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vctrl_obuf_skid #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign w_pop_ok  = i_pop && (r_count != 2'd0);
  assign w_push_ok = i_push && ((r_count != 2'd2) || w_pop_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop_ok) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/vctrl_obuf_drain.sv
// ============================================================================
// Module  : vctrl_obuf_drain
// Brief   : Walks every (row, col) of the banked/shuffled OBuf and streams rows
//           out over valid/ready. Optional clear-after-read: VCTRL_OBUF_DRAIN_CLEAR_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vctrl_obuf_drain
  import vctrl_obuf_drain_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [CfgRowW-1:0]            cfgRowNum,
  input  logic [CfgColW-1:0]            cfgColNum,
  output logic                          busy,
  output logic                          done,
  output logic [OBufBank-1:0]           oBufRdEn,
  output logic [OBufBank*AddrW-1:0]     oBufRdAddr,
  input  logic [OBufBank*DataWidth-1:0] oBufRdData,
  output logic [OBufBank-1:0]           oBufWrEn,
  output logic [OBufBank*AddrW-1:0]     oBufWrAddr,
  output logic                          outValid,
  input  logic                          outReady,
  output logic [BankHalf*DataWidth-1:0] outData,
  output logic [RowW-1:0]               outRow,
  output logic [ColW-1:0]               outCol
);

  localparam int c_beat_w = RowW + ColW + BankHalf * DataWidth;

  drain_state_e                  r_state;
  logic [RowW-1:0]               r_row_ptr;
  logic [ColW-1:0]               r_col_ptr;
  logic [RowW-1:0]               r_row_last;
  logic [ColW-1:0]               r_col_last;
  logic                          r_inflight;
  logic                          r_tag_g;
  logic [RowW-1:0]               r_tag_row;
  logic [ColW-1:0]               r_tag_col;
  logic                          r_busy;
  logic                          r_done;

  logic [1:0]                    w_fifo_count;
  logic                          w_pop;
  logic [2:0]                    w_occupancy;
  logic                          w_issue;
  logic                          w_drained;
  logic [BankHalf*DataWidth-1:0] w_lanes;
  logic [c_beat_w-1:0]           w_head;
  obuf_addr_t                    w_rd_addr [OBufBank];

  assign w_pop = outValid && outReady;

  // Credit counts the slot freed by a pop this cycle so a steady stream keeps
  // one read in flight and one row stored, sustaining one beat per cycle.
  assign w_occupancy = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue     = (r_state == ISSUE) && (w_occupancy < 3'd2);
  assign w_drained   = !r_inflight &&
                       ((w_fifo_count == 2'd0) || ((w_fifo_count == 2'd1) && w_pop));

  for (genvar k = 0; k < OBufBank; k++) begin : g_bank
    localparam logic c_grp  = (k >= BankHalf);
    localparam int   c_lane = k % BankHalf;
    assign oBufRdEn[k]   = w_issue && (r_row_ptr[0] == c_grp);
    assign w_rd_addr[k]  = oBufRdEn[k] ? shuffle_addr(r_col_ptr, r_row_ptr, c_lane) : '0;
    assign oBufRdAddr[k*AddrW +: AddrW] = w_rd_addr[k];
  end

  for (genvar i = 0; i < BankHalf; i++) begin : g_lane
    assign w_lanes[i*DataWidth +: DataWidth] = r_tag_g
        ? oBufRdData[(BankHalf+i)*DataWidth +: DataWidth]
        : oBufRdData[i*DataWidth +: DataWidth];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_row_ptr  <= '0;
      r_col_ptr  <= '0;
      r_row_last <= '0;
      r_col_last <= '0;
      r_inflight <= 1'b0;
      r_tag_g    <= 1'b0;
      r_tag_row  <= '0;
      r_tag_col  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_inflight <= w_issue;
      if (w_issue) begin
        r_tag_g   <= r_row_ptr[0];
        r_tag_row <= r_row_ptr;
        r_tag_col <= r_col_ptr;
      end
      case (r_state)
        IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            if ((cfgRowNum != '0) && (cfgColNum != '0)) begin
              r_state    <= ISSUE;
              r_row_ptr  <= '0;
              r_col_ptr  <= '0;
              r_row_last <= RowW'(cfgRowNum - CfgRowW'(1));
              r_col_last <= ColW'(cfgColNum - CfgColW'(1));
            end else begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ISSUE: begin
          // Row is the inner loop, column the outer.
          if (w_issue) begin
            if (r_row_ptr == r_row_last) begin
              r_row_ptr <= '0;
              if (r_col_ptr == r_col_last) r_state <= FLUSH;
              else                         r_col_ptr <= r_col_ptr + ColW'(1);
            end else begin
              r_row_ptr <= r_row_ptr + RowW'(1);
            end
          end
        end
        FLUSH: begin
          if (w_drained) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  vctrl_obuf_skid #(
    .WIDTH (c_beat_w)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_inflight),
    .i_data  ({r_tag_row, r_tag_col, w_lanes}),
    .i_pop   (outReady),
    .o_valid (outValid),
    .o_data  (w_head),
    .o_count (w_fifo_count)
  );

  assign {outRow, outCol, outData} = w_head;
  assign busy = r_busy;
  assign done = r_done;

`ifdef VCTRL_OBUF_DRAIN_CLEAR_EN
  logic [OBufBank-1:0]       r_wr_en;
  logic [OBufBank*AddrW-1:0] r_wr_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_en   <= '0;
      r_wr_addr <= '0;
    end else begin
      r_wr_en   <= oBufRdEn;
      r_wr_addr <= oBufRdAddr;
    end
  end

  assign oBufWrEn   = r_wr_en;
  assign oBufWrAddr = r_wr_addr;
`else
  assign oBufWrEn   = '0;
  assign oBufWrAddr = '0;
`endif

endmodule

`default_nettype wire
